// File: rtl/mdu_ex_pkg.sv
// Shared definitions for the mdu_ex multiply/divide unit: op encodings, default latencies,
// FSM state type and the core-to-FSM control bundle.
package mdu_ex_pkg;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic launch_ok;  // op is a multi-cycle op that may start
    logic commit;     // result is written to HI/LO when the op retires
    logic is_div;     // selects the divide latency
    logic move;       // mthi/mtlo single-cycle write
  } mdu_ctl_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

endpackage

// File: rtl/mdu_ex_core.sv
// Combinational datapath of mdu_ex: 64-bit product, quotient/remainder and HI/LO merge values.
// The madd/msub family is compiled in only when MDU_MADD_EN is defined.
module mdu_ex_core
  import mdu_ex_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] hilo_i,
  output logic [63:0] res_o,
  output mdu_ctl_t    ctl_o
);

  logic [63:0] prod_u_s;
  logic [63:0] prod_s_s;
  logic        signed_div_s;
  logic [31:0] n_s;
  logic [31:0] d_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_u_s = {32'd0, a_i} * {32'd0, b_i};
  assign prod_s_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

  // Sign-magnitude divider; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    signed_div_s = (op_i == MDU_DIV);
    n_s = (signed_div_s && a_i[31]) ? neg32(a_i) : a_i;
    d_s = (signed_div_s && b_i[31]) ? neg32(b_i) : b_i;
    if (d_s == 32'd0) begin
      q_s = 32'd0;
      r_s = 32'd0;
    end else begin
      q_s = n_s / d_s;
      r_s = n_s % d_s;
    end
    quo_s = (signed_div_s && (a_i[31] ^ b_i[31])) ? neg32(q_s) : q_s;
    rem_s = (signed_div_s && a_i[31]) ? neg32(r_s) : r_s;
  end

  // Op decode: result value and control flags.
  always_comb begin
    res_o = hilo_i;
    ctl_o = '{launch_ok: 1'b0, commit: 1'b0, is_div: 1'b0, move: 1'b0};
    case (op_i)
      MDU_MULT: begin
        res_o           = prod_s_s;
        ctl_o.launch_ok = 1'b1;
        ctl_o.commit    = 1'b1;
      end
      MDU_MULTU: begin
        res_o           = prod_u_s;
        ctl_o.launch_ok = 1'b1;
        ctl_o.commit    = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        res_o           = {rem_s, quo_s};
        ctl_o.launch_ok = 1'b1;
        ctl_o.is_div    = 1'b1;
        // Divide by zero still occupies the unit but leaves HI/LO untouched.
        ctl_o.commit    = (b_i != 32'd0);
      end
      MDU_MTHI: begin
        res_o      = {a_i, hilo_i[31:0]};
        ctl_o.move = 1'b1;
      end
      MDU_MTLO: begin
        res_o      = {hilo_i[63:32], a_i};
        ctl_o.move = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        res_o           = hilo_i + prod_s_s;
        ctl_o.launch_ok = 1'b1;
        ctl_o.commit    = 1'b1;
      end
      MDU_MADDU: begin
        res_o           = hilo_i + prod_u_s;
        ctl_o.launch_ok = 1'b1;
        ctl_o.commit    = 1'b1;
      end
      MDU_MSUB: begin
        res_o           = hilo_i - prod_s_s;
        ctl_o.launch_ok = 1'b1;
        ctl_o.commit    = 1'b1;
      end
      MDU_MSUBU: begin
        res_o           = hilo_i - prod_u_s;
        ctl_o.launch_ok = 1'b1;
        ctl_o.commit    = 1'b1;
      end
`endif
      default: begin
        res_o = hilo_i;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: fixed-latency FSM, shadow result and HI/LO registers.
// Optional madd/maddu/msub/msubu support is enabled with the MDU_MADD_EN macro.
module mdu_ex
  import mdu_ex_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_d;
  logic         busy_q;
  logic         commit_en_q;
  logic [63:0]  shadow_q;
  logic [31:0]  hi_q;
  logic [31:0]  lo_q;

  logic [63:0]  res_s;
  mdu_ctl_t     ctl_s;
  logic         launch_s;
  logic         move_ok_s;

  mdu_ex_core u_core (
    .op_i   (MDUOp),
    .a_i    (A),
    .b_i    (B),
    .hilo_i ({hi_q, lo_q}),
    .res_o  (res_s),
    .ctl_o  (ctl_s)
  );

  // Launch/move qualification and initial counter value.
  always_comb begin
    launch_s  = Start && !Req && !busy_q && ctl_s.launch_ok;
    move_ok_s = ctl_s.move && !Req && !busy_q;
    if (ctl_s.is_div) begin
      lat_d = CNT_W'(DIV_CYCLES - 1);
    end else begin
      lat_d = CNT_W'(MULT_CYCLES - 1);
    end
  end

  // FSM, countdown, shadow capture and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      commit_en_q <= 1'b0;
      shadow_q    <= 64'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch_s) begin
            shadow_q    <= res_s;
            commit_en_q <= ctl_s.commit;
            cnt_q       <= lat_d;
            busy_q      <= 1'b1;
            state_q     <= ST_BUSY;
          end else if (move_ok_s) begin
            hi_q <= res_s[63:32];
            lo_q <= res_s[31:0];
          end
        end
        ST_BUSY: begin
          // Req no longer matters here: the owning instruction has already left EX.
          if (cnt_q == '0) begin
            if (commit_en_q) begin
              hi_q <= shadow_q[63:32];
              lo_q <= shadow_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ex.sv
// Directed self-checking bench for mdu_ex with hand-computed HI/LO results and Busy windows.
module tb_mdu_ex;
  import mdu_ex_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vec_cnt = 0;
  int err_cnt = 0;

  mdu_ex dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .Req(Req),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) assert (!(Start && Busy)) else $error("Start issued while Busy");
  end

  // Called at a negedge; Start is sampled at the next posedge, returns at the following negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    MDUOp = op; A = a; B = b; Start = 1'b1; Req = req;
    @(negedge clk);
    MDUOp = MDU_NONE; Start = 1'b0; Req = 1'b0;
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] a, input logic req);
    MDUOp = op; A = a; Req = req;
    @(negedge clk);
    MDUOp = MDU_NONE; Req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", Busy, HI, LO);
    end
  endtask

  task automatic test_mult;
    issue(MDU_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    for (int i = 0; i < MC; i++) begin
      vec_cnt++;
      if (Busy !== 1'b1 || HI !== 32'h0 || LO !== 32'h0) begin
        err_cnt++;
        $display("FAIL mult_busy[%0d]: busy=%b hi=%h lo=%h, want busy=1 hi=0 lo=0", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
      err_cnt++;
      $display("FAIL mult_result: busy=%b hi=%h lo=%h, want busy=0 hi=ffffffff lo=fffffffe", Busy, HI, LO);
    end
  endtask

  task automatic test_multu;
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    for (int i = 0; i < MC; i++) begin
      vec_cnt++;
      if (Busy !== 1'b1 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
        err_cnt++;
        $display("FAIL multu_busy[%0d]: busy=%b hi=%h lo=%h, want busy=1 hi=ffffffff lo=fffffffe", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
      err_cnt++;
      $display("FAIL multu_result: busy=%b hi=%h lo=%h, want busy=0 hi=00000001 lo=fffffffe", Busy, HI, LO);
    end
  endtask

  task automatic test_div;
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    for (int i = 0; i < DC; i++) begin
      vec_cnt++;
      if (Busy !== 1'b1 || HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
        err_cnt++;
        $display("FAIL div_busy[%0d]: busy=%b hi=%h lo=%h, want busy=1 hi=00000001 lo=fffffffe", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      err_cnt++;
      $display("FAIL div_result: busy=%b hi=%h lo=%h, want busy=0 hi=ffffffff lo=fffffffd", Busy, HI, LO);
    end
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    repeat (DC) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h80000000) begin
      err_cnt++;
      $display("FAIL div_ovf: busy=%b hi=%h lo=%h, want busy=0 hi=00000000 lo=80000000", Busy, HI, LO);
    end
  endtask

  task automatic test_divu;
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (DC) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) begin
      err_cnt++;
      $display("FAIL divu_result: busy=%b hi=%h lo=%h, want busy=0 hi=00000002 lo=0000000e", Busy, HI, LO);
    end
    move(MDU_MTHI, 32'h11, 1'b0);
    move(MDU_MTLO, 32'h22, 1'b0);
    vec_cnt++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      err_cnt++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, want hi=00000011 lo=00000022", HI, LO);
    end
    issue(MDU_DIVU, 32'd100, 32'd0, 1'b0);
    for (int i = 0; i < DC; i++) begin
      vec_cnt++;
      if (Busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL divz_busy[%0d]: busy=%b, want busy=1", i, Busy);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
      err_cnt++;
      $display("FAIL divz_result: busy=%b hi=%h lo=%h, want busy=0 hi=00000011 lo=00000022", Busy, HI, LO);
    end
  endtask

  task automatic test_req;
    issue(MDU_MULT, 32'd5, 32'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (Busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
        err_cnt++;
        $display("FAIL req_start[%0d]: busy=%b hi=%h lo=%h, want busy=0 hi=00000011 lo=00000022", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    move(MDU_MTHI, 32'h55, 1'b1);
    vec_cnt++;
    if (HI !== 32'h11) begin
      err_cnt++;
      $display("FAIL req_mthi: hi=%h, want hi=00000011", HI);
    end
    move(MDU_MTHI, 32'hABCD0000, 1'b0);
    vec_cnt++;
    if (HI !== 32'hABCD0000 || LO !== 32'h22) begin
      err_cnt++;
      $display("FAIL mthi: hi=%h lo=%h, want hi=abcd0000 lo=00000022", HI, LO);
    end
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    Req = 1'b1;
    @(negedge clk);
    Req = 1'b0;
    repeat (MC - 1) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'hC) begin
      err_cnt++;
      $display("FAIL req_busy_commit: busy=%b hi=%h lo=%h, want busy=0 hi=00000000 lo=0000000c", Busy, HI, LO);
    end
  endtask

  task automatic test_none;
    issue(MDU_NONE, 32'd9, 32'd9, 1'b0);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'hC) begin
      err_cnt++;
      $display("FAIL none_start: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0000000c", Busy, HI, LO);
    end
    issue(4'hF, 32'd9, 32'd9, 1'b0);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'hC) begin
      err_cnt++;
      $display("FAIL undef_start: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0000000c", Busy, HI, LO);
    end
    issue(MDU_MADD, 32'hFFFFFFFF, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    repeat (MC - 1) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b1 || LO !== 32'hC) begin
      err_cnt++;
      $display("FAIL madd_busy: busy=%b lo=%h, want busy=1 lo=0000000c", Busy, LO);
    end
    @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h9) begin
      err_cnt++;
      $display("FAIL madd_result: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=00000009", Busy, HI, LO);
    end
`else
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'hC) begin
      err_cnt++;
      $display("FAIL madd_disabled: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0000000c", Busy, HI, LO);
    end
`endif
  endtask

  task automatic test_reset_mid;
    move(MDU_MTHI, 32'h77, 1'b0);
    issue(MDU_DIV, 32'd50, 32'd5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", Busy, HI, LO);
    end
    issue(MDU_MULT, 32'd6, 32'd7, 1'b0);
    repeat (MC - 1) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL post_reset_busy: busy=%b, want busy=1", Busy);
    end
    @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd42) begin
      err_cnt++;
      $display("FAIL post_reset_mult: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0000002a", Busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    issue(MDU_MULTU, 32'h00010000, 32'h00010000, 1'b0);
    repeat (MC) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'h1 || LO !== 32'h0) begin
      err_cnt++;
      $display("FAIL b2b_multu: busy=%b hi=%h lo=%h, want busy=0 hi=00000001 lo=0", Busy, HI, LO);
    end
    issue(MDU_DIV, 32'd100, 32'hFFFFFFF9, 1'b0);
    repeat (DC - 1) @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b1 || HI !== 32'h1 || LO !== 32'h0) begin
      err_cnt++;
      $display("FAIL b2b_div_busy: busy=%b hi=%h lo=%h, want busy=1 hi=00000001 lo=0", Busy, HI, LO);
    end
    @(negedge clk);
    vec_cnt++;
    if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'hFFFFFFF2) begin
      err_cnt++;
      $display("FAIL b2b_div: busy=%b hi=%h lo=%h, want busy=0 hi=00000002 lo=fffffff2", Busy, HI, LO);
    end
  endtask

  initial begin
    reset = 1'b1; MDUOp = MDU_NONE; Start = 1'b0; Req = 1'b0; A = 32'd0; B = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_req();
    test_none();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
